sm_result_fifo: RTL and testbench
=================================

Name: sm_result_fifo

Overview:
- Downstream stage of the 3-beat sum accumulator.
- Captures each 7-bit sum, presented as a one-cycle valid pulse with no backpressure, into a small first-word-fall-through FIFO.
- Re-issues the sums to the consumer over a valid/ready handshake.
- Flags and counts sums lost because the FIFO was full; the upstream stage cannot stall, so losses are reported, not prevented.

Parameters:
- DEPTH, 4, number of entries; power of 2, at least 2.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- i_dval  input  1  one-cycle pulse: i carries a valid sum this cycle.
- i  input  7  sum from the upstream accumulator.
- i_clr  input  1  synchronous clear of o_ovf and o_drop.
- o_rdy  input  1  consumer accepts the head entry this cycle.
- o_dval  output  1  FIFO non-empty; head valid on o.
- o  output  7  head entry; 0 when empty.
- o_cnt  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- o_ovf  output  1  sticky: at least one sum dropped since reset/clear.
- o_drop  output  DROP_W  number of dropped sums, saturating.

Behaviour:
- Reset (rst low, async) clears:
  - rd/wr pointers and occupancy;
  - o_dval=0, o=0, o_cnt=0, o_ovf=0, o_drop=0.
  - Storage contents are don't-care. A reset mid-stream discards all entries immediately, without waiting for a clock edge.
- Pop: occurs when o_dval && o_rdy. Head advances at the edge. o_rdy with o_dval=0 is ignored.
- Push: occurs when i_dval && (o_cnt<DEPTH || pop).
  - Full plus a simultaneous pop accepts the new sum; occupancy stays DEPTH.
- Latency: a sum pushed at edge N is visible on o/o_dval after edge N, provided the FIFO was empty. Otherwise it is visible after all older entries are popped.
- Order: strict FIFO. Pointers wrap modulo DEPTH.
- o_cnt next-state:
  - push only: +1
  - pop only: -1
  - both, or neither: unchanged
- o_dval = (o_cnt != 0). o is taken from storage at the rd pointer and forced to 0 when empty. Both are pure functions of registered state; there is no combinational path from i/i_dval to the outputs.
- Push and pop on the same cycle with o_cnt=0 cannot occur, because pop requires o_dval=1. No bypass path: an empty FIFO shows the sum one cycle later.
- Drop: occurs when i_dval && o_cnt==DEPTH && !pop.
  - The sum is discarded and the FIFO is unchanged.
  - o_ovf sets at the edge.
  - o_drop increments and saturates at 2^DROP_W-1; it never wraps.
- i_clr at an edge: o_ovf<=0 and o_drop<=0.
  - If a drop occurs in the same cycle, the drop wins the event: o_ovf<=1 and o_drop<=1. The loss is never hidden.
  - i_clr does not affect FIFO contents or occupancy.
- Width rules: o and storage are 7 bits, matching the upstream sum range 0..90. No arithmetic on data.
- Consumer handshake: o and o_dval hold stable while o_dval && !o_rdy. The consumer may hold o_rdy high indefinitely.

Test Plan:
- Reset then idle 5 cycles -> o_dval=0, o=0, o_cnt=0, o_ovf=0, o_drop=0 throughout.
- o_rdy=1; pulse i_dval with i=12, 30, 90 on alternate cycles -> o shows 12, 30, 90, each 1 cycle after its push, each with o_dval high for exactly 1 cycle; o_cnt never exceeds 1.
- o_rdy=0; push 1,2,3,4 (DEPTH=4), then push 5 and 6 -> o_cnt=4, o_ovf=1, o_drop=2. Raise o_rdy -> o pops 1,2,3,4 in order, then o_dval=0.
- Full FIFO holding 1..4; i_dval with i=7 and o_rdy=1 in the same cycle -> no drop (o_drop unchanged), o_cnt stays 4, next head=2, and 7 emerges after 4.
- o_drop at 254; cause 3 more drops -> o_drop=255 and stays 255. Then i_clr with a simultaneous drop -> o_ovf=1, o_drop=1. Then i_clr alone -> o_ovf=0, o_drop=0.
- 3 entries queued, rst pulsed low mid-cycle -> o_dval=0, o_cnt=0 immediately (async). After release, push 9 -> o=9, with no stale entries emerging.

Source files
------------

// File: rtl/sm_result_fifo_if.sv
// Result FIFO bus: upstream sum pulse, clear, consumer handshake and status.
// No latency or backpressure of its own; the slave side is the FIFO.
// Consumer stalls via o_rdy; the upstream pulse side has no backpressure.
interface sm_result_fifo_if #(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              i_dval;
  logic [6:0]        i;
  logic              i_clr;
  logic              o_rdy;
  logic              o_dval;
  logic [6:0]        o;
  logic [CW-1:0]     o_cnt;
  logic              o_ovf;
  logic [DROP_W-1:0] o_drop;

  modport slave (
    input  i_dval, i, i_clr, o_rdy,
    output o_dval, o, o_cnt, o_ovf, o_drop
  );

  modport master (
    output i_dval, i, i_clr, o_rdy,
    input  o_dval, o, o_cnt, o_ovf, o_drop
  );
endinterface

// File: rtl/sm_result_fifo.sv
// First-word-fall-through FIFO for 7-bit sums with sticky overflow and drop count.
// Latency: a push into an empty FIFO shows on o one cycle later; no bypass.
// Backpressure: o_rdy stalls the head; a push into a full FIFO without a pop is dropped.
module sm_result_fifo #(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  sm_result_fifo_if.slave     bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [6:0]        r_mem [DEPTH];
  logic [AW-1:0]     r_wr;
  logic [AW-1:0]     r_rd;
  logic [CW-1:0]     r_cnt;
  logic              r_ovf;
  logic [DROP_W-1:0] r_drop;

  logic w_nonempty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_sat;

  assign w_nonempty = (r_cnt != '0);
  assign w_full     = (r_cnt == CW'(DEPTH));
  assign w_pop      = w_nonempty && bus.o_rdy;
  assign w_push     = bus.i_dval && (!w_full || w_pop);
  assign w_drop     = bus.i_dval && w_full && !w_pop;
  assign w_sat      = (r_drop == {DROP_W{1'b1}});

  // Storage is don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= bus.i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_pop && !w_push) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // A drop in the same cycle as a clear still gets recorded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (bus.i_clr) begin
        r_drop <= DROP_W'(1);
      end else if (!w_sat) begin
        r_drop <= r_drop + 1'b1;
      end
    end else if (bus.i_clr) begin
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end
  end

  assign bus.o_dval = w_nonempty;
  assign bus.o      = w_nonempty ? r_mem[r_rd] : 7'd0;
  assign bus.o_cnt  = r_cnt;
  assign bus.o_ovf  = r_ovf;
  assign bus.o_drop = r_drop;
endmodule

// File: tb/tb_sm_result_fifo.sv
// Directed bench for sm_result_fifo (DEPTH=4, DROP_W=8) with hand-computed expectations.
module tb_sm_result_fifo;
  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;
  int   n_fail;

  sm_result_fifo_if #(.DEPTH(4), .DROP_W(8)) bus ();

  sm_result_fifo #(.DEPTH(4), .DROP_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag, input int drop, input logic ovf);
    chk({tag, " o_dval"}, 32'(bus.o_dval), 32'd0);
    chk({tag, " o"},      32'(bus.o),      32'd0);
    chk({tag, " o_cnt"},  32'(bus.o_cnt),  32'd0);
    chk({tag, " o_ovf"},  32'(bus.o_ovf),  32'(ovf));
    chk({tag, " o_drop"}, 32'(bus.o_drop), 32'(drop));
  endtask

  task automatic fill4();
    bus.o_rdy  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      bus.i_dval = 1'b1;
      bus.i      = 7'(k);
      tick();
    end
    bus.i_dval = 1'b0;
  endtask

  initial begin
    int exp_q[4];
    n_total = 0;
    n_pass  = 0;
    n_fail  = 0;
    rst        = 1'b0;
    bus.i_dval = 1'b0;
    bus.i      = 7'd0;
    bus.i_clr  = 1'b0;
    bus.o_rdy  = 1'b0;
    #12;
    chk_idle("in_reset", 0, 1'b0);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_idle("idle", 0, 1'b0);
    end

    // Streaming with consumer always ready
    bus.o_rdy = 1'b1;
    exp_q = '{12, 30, 90, 0};
    for (int k = 0; k < 3; k++) begin
      bus.i_dval = 1'b1;
      bus.i      = 7'(exp_q[k]);
      tick();
      bus.i_dval = 1'b0;
      chk("stream o_dval", 32'(bus.o_dval), 32'd1);
      chk("stream o",      32'(bus.o),      32'(exp_q[k]));
      chk("stream o_cnt",  32'(bus.o_cnt),  32'd1);
      tick();
      chk("stream gap o_dval", 32'(bus.o_dval), 32'd0);
      chk("stream gap o_cnt",  32'(bus.o_cnt),  32'd0);
    end

    // Fill, overflow by two, drain in order
    fill4();
    chk("full o_cnt", 32'(bus.o_cnt), 32'd4);
    chk("full o_ovf", 32'(bus.o_ovf), 32'd0);
    for (int k = 5; k <= 6; k++) begin
      bus.i_dval = 1'b1;
      bus.i      = 7'(k);
      tick();
    end
    bus.i_dval = 1'b0;
    chk("ovf o_cnt",  32'(bus.o_cnt),  32'd4);
    chk("ovf o_ovf",  32'(bus.o_ovf),  32'd1);
    chk("ovf o_drop", 32'(bus.o_drop), 32'd2);
    chk("ovf hold o", 32'(bus.o),      32'd1);
    tick();
    chk("stall hold o", 32'(bus.o), 32'd1);
    bus.o_rdy = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("drain o_dval", 32'(bus.o_dval), 32'd1);
      chk("drain o",      32'(bus.o),      32'(k));
      tick();
    end
    chk_idle("drained", 2, 1'b1);

    // Full plus simultaneous pop accepts the push
    fill4();
    bus.i_dval = 1'b1;
    bus.i      = 7'd7;
    bus.o_rdy  = 1'b1;
    tick();
    bus.i_dval = 1'b0;
    chk("fullpop o_drop", 32'(bus.o_drop), 32'd2);
    chk("fullpop o_cnt",  32'(bus.o_cnt),  32'd4);
    exp_q = '{2, 3, 4, 7};
    for (int k = 0; k < 4; k++) begin
      chk("fullpop o", 32'(bus.o), 32'(exp_q[k]));
      tick();
    end
    chk_idle("fullpop empty", 2, 1'b1);

    // Drop counter saturation and clear interaction
    fill4();
    bus.i_dval = 1'b1;
    bus.i      = 7'd50;
    for (int k = 0; k < 252; k++) tick();
    chk("drop 254", 32'(bus.o_drop), 32'd254);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("drop sat", 32'(bus.o_drop), 32'd255);
    end
    bus.i_clr = 1'b1;
    tick();
    chk("clr+drop o_ovf",  32'(bus.o_ovf),  32'd1);
    chk("clr+drop o_drop", 32'(bus.o_drop), 32'd1);
    bus.i_dval = 1'b0;
    tick();
    bus.i_clr = 1'b0;
    chk("clr o_ovf",  32'(bus.o_ovf),  32'd0);
    chk("clr o_drop", 32'(bus.o_drop), 32'd0);
    chk("clr o_cnt",  32'(bus.o_cnt),  32'd4);
    chk("clr o",      32'(bus.o),      32'd1);

    // Asynchronous reset mid-stream
    bus.o_rdy = 1'b1;
    tick();
    bus.o_rdy = 1'b0;
    chk("pre-rst o_cnt", 32'(bus.o_cnt), 32'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("async rst o_dval", 32'(bus.o_dval), 32'd0);
    chk("async rst o_cnt",  32'(bus.o_cnt),  32'd0);
    chk("async rst o",      32'(bus.o),      32'd0);
    #1;
    rst = 1'b1;
    bus.i_dval = 1'b1;
    bus.i      = 7'd9;
    tick();
    bus.i_dval = 1'b0;
    chk("post-rst o",      32'(bus.o),      32'd9);
    chk("post-rst o_cnt",  32'(bus.o_cnt),  32'd1);
    bus.o_rdy = 1'b1;
    tick();
    chk_idle("post-rst drained", 0, 1'b0);
    tick();
    chk("no stale o_dval", 32'(bus.o_dval), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
